// File: rtl/l2_tlb_search_ctrl.sv
// L2 TLB search sequencer: walks one set two entries per cycle over a dual-port
// tag RAM, merges configuration writes, and returns one registered result per request.
module l2_tlb_search_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int PAGE_SIZE      = 4096,
  parameter int SET_WIDTH      = 5,
  parameter int OFFSET_WIDTH   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ADDR_WIDTH-1:0]               in_addr,
  input  logic                                in_rw_type,
  input  logic                                cfg_we,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]     cfg_addr,
  input  logic [RAM_DATA_WIDTH-1:0]           cfg_wdata,
  output logic                                ram_we,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     port0_addr,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     port1_addr,
  output logic [RAM_DATA_WIDTH-1:0]           ram_wdata,
  output logic [ADDR_WIDTH-1:0]               chk_addr,
  output logic                                chk_rw_type,
  output logic                                output_valid,
  output logic [OFFSET_WIDTH-1:0]             offset_addr_d,
  output logic                                output_sent,
  input  logic                                chk_hit,
  input  logic                                chk_multi_hit,
  input  logic                                chk_prot,
  input  logic                                chk_master,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]     chk_hit_addr,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_hit,
  output logic                                out_miss,
  output logic                                out_multi_hit,
  output logic                                out_prot,
  output logic                                out_master,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     out_hit_addr
);

  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int EA_W       = SET_WIDTH + OFFSET_WIDTH + 1;
  localparam logic [OFFSET_WIDTH-1:0] OFF_MAX = {OFFSET_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      rw_q, rw_d;
  logic [SET_WIDTH-1:0]      set_q, set_d;
  logic [OFFSET_WIDTH-1:0]   offset_cnt_q, offset_cnt_d;
  logic [OFFSET_WIDTH-1:0]   ret_off_q, ret_off_d;
  logic                      issued_all_q, issued_all_d;
  logic                      issue_q, issue_d;
  logic                      last_q, last_d;
  logic                      hit_q, hit_d;
  logic                      miss_q, miss_d;
  logic                      multi_q, multi_d;
  logic                      prot_q, prot_d;
  logic                      master_q, master_d;
  logic [EA_W-1:0]           hit_addr_q, hit_addr_d;

  // Next-state logic: request accept, read issue, result capture and handshake.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    set_d        = set_q;
    offset_cnt_d = offset_cnt_q;
    ret_off_d    = ret_off_q;
    issued_all_d = issued_all_q;
    issue_d      = issue_q;
    last_d       = last_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    multi_d      = multi_q;
    prot_d       = prot_q;
    master_d     = master_q;
    hit_addr_d   = hit_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          addr_d       = in_addr;
          rw_d         = in_rw_type;
          set_d        = in_addr[IGNORE_LSB +: SET_WIDTH];
          offset_cnt_d = {OFFSET_WIDTH{1'b0}};
          issued_all_d = 1'b0;
          issue_d      = 1'b0;
          last_d       = 1'b0;
          state_d      = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEARCH: begin
        // A configuration write steals port 0, so the walk stalls for that cycle.
        if (!cfg_we && !issued_all_q) begin
          issue_d   = 1'b1;
          ret_off_d = offset_cnt_q;
          if (offset_cnt_q == OFF_MAX) begin
            issued_all_d = 1'b1;
            last_d       = 1'b1;
          end else begin
            offset_cnt_d = offset_cnt_q + {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          issue_d = 1'b0;
        end

        if (issue_q) begin
          if (chk_hit) begin
            hit_d      = 1'b1;
            miss_d     = 1'b0;
            multi_d    = chk_multi_hit;
            prot_d     = chk_prot;
            master_d   = chk_master;
            hit_addr_d = chk_hit_addr;
            issue_d    = 1'b0;
            state_d    = ST_DONE;
          end else if (last_q) begin
            hit_d      = 1'b0;
            miss_d     = 1'b1;
            multi_d    = 1'b0;
            prot_d     = 1'b0;
            master_d   = 1'b0;
            hit_addr_d = {EA_W{1'b0}};
            issue_d    = 1'b0;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          hit_d      = 1'b0;
          miss_d     = 1'b0;
          multi_d    = 1'b0;
          prot_d     = 1'b0;
          master_d   = 1'b0;
          hit_addr_d = {EA_W{1'b0}};
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      rw_q         <= 1'b0;
      set_q        <= {SET_WIDTH{1'b0}};
      offset_cnt_q <= {OFFSET_WIDTH{1'b0}};
      ret_off_q    <= {OFFSET_WIDTH{1'b0}};
      issued_all_q <= 1'b0;
      issue_q      <= 1'b0;
      last_q       <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      multi_q      <= 1'b0;
      prot_q       <= 1'b0;
      master_q     <= 1'b0;
      hit_addr_q   <= {EA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      set_q        <= set_d;
      offset_cnt_q <= offset_cnt_d;
      ret_off_q    <= ret_off_d;
      issued_all_q <= issued_all_d;
      issue_q      <= issue_d;
      last_q       <= last_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      multi_q      <= multi_d;
      prot_q       <= prot_d;
      master_q     <= master_d;
      hit_addr_q   <= hit_addr_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign ram_we        = cfg_we;
  assign ram_wdata     = cfg_wdata;
  assign port0_addr    = cfg_we ? cfg_addr : {1'b0, set_q, offset_cnt_q};
  assign port1_addr    = {1'b1, set_q, offset_cnt_q};
  assign chk_addr      = addr_q;
  assign chk_rw_type   = rw_q;
  // Read data only counts while searching; a read in flight after a hit is dropped.
  assign output_valid  = (state_q == ST_SEARCH) && issue_q;
  assign offset_addr_d = ret_off_q;
  assign out_valid     = (state_q == ST_DONE);
  assign output_sent   = out_valid && out_ready;
  assign out_hit       = hit_q;
  assign out_miss      = miss_q;
  assign out_multi_hit = multi_q;
  assign out_prot      = prot_q;
  assign out_master    = master_q;
  assign out_hit_addr  = hit_addr_q;

endmodule

// File: tb/tb_l2_tlb_search_ctrl.sv
// Randomized/directed bench for l2_tlb_search_ctrl; the check stage is emulated
// and results/timing come from a cycle-count reference model.
module tb_l2_tlb_search_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic        in_rw_type;
  logic        cfg_we;
  logic [9:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        ram_we;
  logic [9:0]  port0_addr;
  logic [9:0]  port1_addr;
  logic [31:0] ram_wdata;
  logic [31:0] chk_addr;
  logic        chk_rw_type;
  logic        output_valid;
  logic [3:0]  offset_addr_d;
  logic        output_sent;
  logic        chk_hit, chk_multi_hit, chk_prot, chk_master;
  logic [9:0]  chk_hit_addr;
  logic        out_valid;
  logic        out_ready;
  logic        out_hit, out_miss, out_multi_hit, out_prot, out_master;
  logic [9:0]  out_hit_addr;

  int checks = 0;
  int errors = 0;

  l2_tlb_search_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_rw_type(in_rw_type),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ram_we(ram_we), .port0_addr(port0_addr), .port1_addr(port1_addr), .ram_wdata(ram_wdata),
    .chk_addr(chk_addr), .chk_rw_type(chk_rw_type),
    .output_valid(output_valid), .offset_addr_d(offset_addr_d), .output_sent(output_sent),
    .chk_hit(chk_hit), .chk_multi_hit(chk_multi_hit), .chk_prot(chk_prot),
    .chk_master(chk_master), .chk_hit_addr(chk_hit_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_miss(out_miss), .out_multi_hit(out_multi_hit),
    .out_prot(out_prot), .out_master(out_master), .out_hit_addr(out_hit_addr)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: reads go out on consecutive non-cfg_we cycles starting at cycle 1;
  // the result appears two cycles after the read of the deciding offset K.
  function automatic int done_cycle(input int k_last, input logic [63:0] mask);
    int n = 0;
    for (int c = 1; c < 64; c++) begin
      if (!mask[c]) begin
        if (n == k_last) return c + 2;
        n++;
      end
    end
    return -1;
  endfunction

  // One request: k < 0 means no entry matches (miss). Starts right after a negedge.
  task automatic run_req(input logic [31:0] addr, input logic rw, input int k,
                         input logic [63:0] mask, input logic mh, input logic pr,
                         input logic ms, input logic port, input int rdy_delay);
    int          k_last;
    int          exp_cyc;
    int          cyc;
    int          nexp;
    bit          done;
    logic [4:0]  set_b;
    logic [3:0]  k_b;
    logic [31:0] r;
    logic [9:0]  exp_ha;
    k_last  = (k < 0) ? 15 : k;
    exp_cyc = done_cycle(k_last, mask);
    set_b   = addr[16:12];
    k_b     = k_last[3:0];
    exp_ha  = {port, set_b, k_b};
    cyc     = 0;
    nexp    = 0;
    done    = 1'b0;

    @(posedge clk_i); #1;
    in_valid = 1'b1; in_addr = addr; in_rw_type = rw;
    cfg_we = 1'b0; out_ready = 1'b0; chk_hit = 1'b0;
    @(negedge clk_i);
    check("accept_ready", in_ready, 1'b1);

    while (!done && cyc < 70) begin
      @(posedge clk_i); #1;
      cyc++;
      in_valid  = 1'b0;
      cfg_we    = (cyc < 64) ? mask[cyc] : 1'b0;
      r = $urandom; cfg_addr = r[9:0];
      cfg_wdata = $urandom;
      chk_hit       = output_valid && (k >= 0) && (offset_addr_d == k_b);
      chk_multi_hit = mh; chk_prot = pr; chk_master = ms;
      r = $urandom;
      chk_hit_addr  = chk_hit ? exp_ha : r[9:0];
      @(negedge clk_i);
      check("ram_we", ram_we, cfg_we);
      check("ram_wdata", ram_wdata, cfg_wdata);
      if (cfg_we) check("port0_cfg", port0_addr, cfg_addr);
      else        check("port0_set", port0_addr[9:4], {1'b0, set_b});
      check("port1_set", port1_addr[9:4], {1'b1, set_b});
      if (out_valid) begin
        done = 1'b1;
        check("done_cycle", cyc, exp_cyc);
        check("reads_seen", nexp, k_last + 1);
        check("inflight_dropped", output_valid, 1'b0);
        check("out_hit", out_hit, (k >= 0));
        check("out_miss", out_miss, (k < 0));
        check("out_multi", out_multi_hit, (k >= 0) ? mh : 1'b0);
        check("out_prot", out_prot, (k >= 0) ? pr : 1'b0);
        check("out_master", out_master, (k >= 0) ? ms : 1'b0);
        check("out_hit_addr", out_hit_addr, (k >= 0) ? exp_ha : 10'd0);
      end else if (output_valid) begin
        check("ret_offset", offset_addr_d, nexp);
        check("chk_addr", chk_addr, addr);
        check("chk_rw", chk_rw_type, rw);
        nexp++;
      end
    end
    if (!done) check("timeout", 1'b0, 1'b1);

    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clk_i); #1;
      cfg_we = 1'b0; chk_hit = 1'b0;
      @(negedge clk_i);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_hit", out_hit, (k >= 0));
      check("hold_miss", out_miss, (k < 0));
      check("hold_no_sent", output_sent, 1'b0);
    end
    @(posedge clk_i); #1;
    cfg_we = 1'b0; chk_hit = 1'b0; out_ready = 1'b1;
    @(negedge clk_i);
    check("output_sent", output_sent, 1'b1);
    @(posedge clk_i); #1;
    out_ready = 1'b0;
    @(negedge clk_i);
    check("post_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_hit_clr", out_hit, 1'b0);
    check("post_miss_clr", out_miss, 1'b0);
    check("post_sent", output_sent, 1'b0);
  endtask

  // Reset asserted asynchronously once offset 7 returns.
  task automatic reset_mid_search(input logic [31:0] addr);
    int  cyc;
    bit  hit7;
    cyc  = 0;
    hit7 = 1'b0;
    @(posedge clk_i); #1;
    in_valid = 1'b1; in_addr = addr; in_rw_type = 1'b0; cfg_we = 1'b0; chk_hit = 1'b0;
    while (!hit7 && cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
      in_valid = 1'b0;
      @(negedge clk_i);
      if (output_valid && offset_addr_d == 4'd7) hit7 = 1'b1;
    end
    check("reached_off7", hit7, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_output_valid", output_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_chk_addr", chk_addr, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    logic [63:0] mask;
    logic [31:0] a;
    int          k;
    rst_i = 1'b1; in_valid = 1'b0; in_addr = 32'd0; in_rw_type = 1'b0;
    cfg_we = 1'b0; cfg_addr = 10'd0; cfg_wdata = 32'd0;
    chk_hit = 1'b0; chk_multi_hit = 1'b0; chk_prot = 1'b0; chk_master = 1'b0;
    chk_hit_addr = 10'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_output_valid", output_valid, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_outs", {out_hit, out_miss, out_multi_hit, out_prot, out_master}, 5'd0);
    check("reset_hit_addr", out_hit_addr, 10'd0);
    check("reset_offset", offset_addr_d, 4'd0);
    check("reset_chk_addr", chk_addr, 32'd0);
    rst_i = 1'b0;

    // Directed: hit on port1 at offset 3 of set 0x15
    run_req(32'h0003_5ABC, 1'b0, 3, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    // Full miss
    run_req(32'h1234_7000, 1'b0, -1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Two cfg_we cycles where offset 5 would issue, then miss
    run_req(32'h0000_B123, 1'b1, -1, 64'h0000_0000_0000_00C0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Multi-hit at offset 0 with protection fault on a write
    run_req(32'hFFFF_F000, 1'b1, 0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    // Hit on the last read, and cfg_we in the cycle the result returns
    run_req(32'h0001_F000, 1'b0, 15, 64'h0000_0000_0002_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Consumer stalls 5 cycles in DONE
    run_req(32'h0004_2000, 1'b0, 9, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    // Async reset mid-search, then a fresh request restarts at offset 0
    reset_mid_search(32'h0002_3000);
    run_req(32'h0002_3000, 1'b0, 2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    for (int n = 0; n < 20; n++) begin
      mask = 64'd0;
      for (int c = 1; c < 31; c++) mask[c] = ($urandom_range(0, 5) == 0);
      a = $urandom;
      k = $urandom_range(0, 16);
      if (k == 16) k = -1;
      run_req(a, a[0], k, mask, a[1], a[2], a[3], a[4], $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_tlb_search_ctrl.md
Name: l2_tlb_search_ctrl

Overview:
Upstream sequencer for the L2 TLB set-associative check stage. It accepts one translation request at a time and derives the set index from the virtual page number. It walks the set two entries per cycle by driving both ports of the dual-port tag/data RAM, and generates the output_valid and output_sent handshake the check stage consumes. It collects the hit, miss, multi-hit and protection results, merges configuration writes into the RAM port stream, and returns one registered result per request.

Parameters:
ADDR_WIDTH, 32, virtual address width.
RAM_DATA_WIDTH, 32, RAM entry width (pass-through for write data).
PAGE_SIZE, 4096, page size in bytes; IGNORE_LSB = log2(PAGE_SIZE).
SET_WIDTH, 5, set index bits taken from in_addr[IGNORE_LSB+SET_WIDTH-1:IGNORE_LSB].
OFFSET_WIDTH, 4, entry-within-bank bits; each bank holds 2^OFFSET_WIDTH entries per set.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
in_addr  in  ADDR_WIDTH  virtual address.
in_rw_type  in  1  1 = write, 0 = read.
cfg_we  in  1  configuration RAM write; has priority over search.
cfg_addr  in  SET_WIDTH+OFFSET_WIDTH+1  configuration write address {bank,set,offset}.
cfg_wdata  in  RAM_DATA_WIDTH  configuration write data.
ram_we  out  1  equals cfg_we (combinational).
port0_addr  out  SET_WIDTH+OFFSET_WIDTH+1  equals cfg_addr when cfg_we; otherwise {1'b0,set_q,offset_cnt}.
port1_addr  out  SET_WIDTH+OFFSET_WIDTH+1  {1'b1,set_q,offset_cnt}.
ram_wdata  out  RAM_DATA_WIDTH  equals cfg_wdata.
chk_addr  out  ADDR_WIDTH  latched request address.
chk_rw_type  out  1  latched rw type.
output_valid  out  1  RAM read data from the previous cycle is valid.
offset_addr_d  out  OFFSET_WIDTH  offset of the read now returning.
output_sent  out  1  equals out_valid && out_ready.
chk_hit, chk_multi_hit, chk_prot, chk_master  in  1 each  results from the check stage.
chk_hit_addr  in  SET_WIDTH+OFFSET_WIDTH+1  hit entry address from the check stage.
out_valid  out  1  result valid.
out_ready  in  1  result consumer ready.
out_hit, out_miss, out_multi_hit, out_prot, out_master  out  1 each  registered result.
out_hit_addr  out  SET_WIDTH+OFFSET_WIDTH+1  registered hit address.

Behaviour:
- FSM states: IDLE, SEARCH, DONE. Reset puts the FSM in IDLE and clears all registers. Reset values of outputs: in_ready=1, output_valid=0, out_valid=0, all out_* = 0, offset_addr_d=0, chk_addr=0.
- IDLE:
  - in_ready=1.
  - On accept: latch in_addr, in_rw_type and set_q; clear offset_cnt and the issued_all flag; go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Issue a read in every cycle with !cfg_we && !issued_all. Register issue_q<=1 and offset_addr_d<=offset_cnt.
  - If offset_cnt equals 2^OFFSET_WIDTH-1, set issued_all and register last_q<=1. Otherwise increment offset_cnt.
  - In a cycle with cfg_we, no read is issued: offset_cnt is held and issue_q<=0.
  - output_valid = issue_q.
- Result capture, in any cycle of SEARCH with output_valid:
  - If chk_hit: register out_hit=1, out_prot=chk_prot, out_multi_hit=chk_multi_hit, out_master=chk_master, out_hit_addr=chk_hit_addr; go to DONE.
  - Else if last_q: register out_miss=1 and all other results 0; go to DONE.
  - The one read still in flight after a hit is discarded: output_valid is forced 0 outside SEARCH, and issue_q is cleared on leaving SEARCH.
- DONE:
  - out_valid=1, held stable until out_ready.
  - On out_valid && out_ready, output_sent=1 for one cycle, then IDLE. The out_* registers are cleared on this transition.
- Latency: with accept in cycle 0 and a hit at offset k with no cfg_we, out_valid rises in cycle k+3. A full miss gives out_valid in cycle 2^OFFSET_WIDTH+2 (18 at defaults). Each cfg_we cycle during SEARCH adds one cycle.
- cfg_we is accepted in any state; ram_we follows it in the same cycle. No new request is accepted while in SEARCH or DONE.
- Simultaneous events:
  - A hit on the return of the last read is reported as a hit, not a miss.
  - cfg_we in the cycle a result returns: the capture still occurs, because output_valid reflects the previous cycle.
- out_miss and out_hit are mutually exclusive.

Test Plan:
- Request in_addr=0x0003_5ABC, hit on port1 at offset 3, cfg_we=0 -> port*_addr carry set 0x15; out_hit=1 and out_hit_addr={1,0x15,3} with out_valid in cycle 6; one output_sent pulse.
- Request with no matching entry -> 16 reads on offsets 0..15; out_miss=1 at cycle 18; output_valid high for exactly 16 cycles.
- cfg_we pulsed for 2 cycles at offset 5 during SEARCH -> offset_cnt held, output_valid low for the matching 2 cycles, ram_we=1 with port0_addr=cfg_addr; a miss completes at cycle 20.
- Hit on port0 and port1 at offset 0 with chk_prot=1 and rw_type=1 -> out_hit=1, out_multi_hit=1, out_prot=1; the in-flight offset-1 read is ignored.
- out_ready held low 5 cycles in DONE -> out_* stable; in_ready stays 0; IDLE is entered only after the handshake.
- rst_i asserted mid-SEARCH at offset 7 -> asynchronous return to IDLE, output_valid=0, out_valid=0; a new request restarts at offset 0.
